// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle CPU core: opcodes, R-type functs,
// FSM state encoding and ALU operation encoding.
package mcpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_J     = 4'd5;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_SLT = 4'd4;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_ZERO
    } alu_op_t;

    // Unknown functs map to ALU_ZERO so the write-back still happens with 0.
    function automatic alu_op_t funct_alu_op(input logic [3:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ZERO;
        endcase
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_J) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/mcpu_mem_if.sv
// Unified instruction/data memory port with a req/ack handshake.
interface mcpu_mem_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mcpu_regfile.sv
// Register file: two async read ports, one sync write port, R0 hardwired to 0.
module mcpu_regfile #(
    parameter int DATA_W = 24,
    parameter int REGA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REGA_W-1:0] ra1,
    input  logic [REGA_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REGA_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);
    localparam int NREGS = 2 ** REGA_W;

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
endmodule

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle CPU core: FSM-sequenced datapath sharing one req/ack memory port.
// Define MCPU_TRAP_EN to halt with trap=1 on illegal opcodes (else they are NOPs).
module multicycle_cpu_core
    import mcpu_pkg::*;
#(
    parameter int                DATA_W   = 24,
    parameter int                REGA_W   = 2,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    mcpu_mem_if.master        mem,
    output logic              halted,
    output logic              trap,
    output logic [ADDR_W-1:0] pc_dbg
);
    localparam int RS_LSB = DATA_W - 4 - REGA_W;
    localparam int RT_LSB = RS_LSB - REGA_W;
    localparam int RD_LSB = RT_LSB - REGA_W;

    state_t                   state, state_n;
    logic [ADDR_W-1:0]        pc;
    logic [DATA_W-1:0]        ir;
    logic signed [DATA_W-1:0] a_q, b_q, aluout, mdr;

    logic [3:0]               op, funct;
    logic [REGA_W-1:0]        rs, rt, rd;
    logic signed [DATA_W-1:0] imm_sext;

    assign op       = ir[DATA_W-1 -: 4];
    assign rs       = ir[RS_LSB +: REGA_W];
    assign rt       = ir[RT_LSB +: REGA_W];
    assign rd       = ir[RD_LSB +: REGA_W];
    assign funct    = ir[3:0];
    assign imm_sext = {{(DATA_W-16){ir[15]}}, ir[15:0]};

    function automatic logic signed [DATA_W-1:0] alu_fn(
        input alu_op_t f, input logic signed [DATA_W-1:0] x, input logic signed [DATA_W-1:0] y);
        case (f)
            ALU_ADD: return x + y;
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_SLT: return {{(DATA_W-1){1'b0}}, (x < y)};
            default: return '0;
        endcase
    endfunction

    // Register file
    logic [DATA_W-1:0] rf_rd1, rf_rd2, rf_wd;
    logic [REGA_W-1:0] rf_wa;
    logic              rf_we;

    mcpu_regfile #(.DATA_W(DATA_W), .REGA_W(REGA_W)) u_rf (
        .clk (clk),   .rst (rst),
        .ra1 (rs),    .ra2 (rt),
        .rd1 (rf_rd1), .rd2 (rf_rd2),
        .we  (rf_we), .wa  (rf_wa), .wd (rf_wd)
    );

    assign rf_we = (state == S_WB);
    assign rf_wa = (op == OP_RTYPE) ? rd : rt;
    assign rf_wd = (op == OP_LW) ? mdr : aluout;

    // ALU: R-type uses B and funct, everything else is A + sext(imm)
    alu_op_t                  alu_op;
    logic signed [DATA_W-1:0] alu_b, alu_y;

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm_sext;
        if (op == OP_RTYPE) begin
            alu_op = funct_alu_op(funct);
            alu_b  = b_q;
        end
        alu_y = alu_fn(alu_op, a_q, alu_b);
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:  if (mem.mem_ack) state_n = S_DECODE;
            S_DECODE: begin
                if (op == OP_HALT) begin
                    state_n = S_HALT;
                end else if (!op_is_legal(op)) begin
`ifdef MCPU_TRAP_EN
                    state_n = S_HALT;
`else
                    state_n = S_FETCH;
`endif
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_LW, OP_SW:      state_n = S_MEM;
                    OP_RTYPE, OP_ADDI: state_n = S_WB;
                    default:           state_n = S_FETCH;
                endcase
            end
            S_MEM:    if (mem.mem_ack) state_n = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     state_n = S_FETCH;
            default:  state_n = S_HALT;
        endcase
    end

    // Control state: FSM, PC, IR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_n;
            if (state == S_FETCH && mem.mem_ack) begin
                ir <= mem.mem_rdata;
                pc <= pc + ADDR_W'(1);
            end else if (state == S_EXEC) begin
                if (op == OP_BEQ && a_q == b_q) pc <= pc + imm_sext[ADDR_W-1:0];
                else if (op == OP_J)            pc <= ir[ADDR_W-1:0];
            end
        end
    end

    // Datapath latches: only consumed in the states that follow their load
    always_ff @(posedge clk) begin
        case (state)
            S_DECODE: begin
                a_q <= rf_rd1;
                b_q <= rf_rd2;
            end
            S_EXEC:   aluout <= alu_y;
            S_MEM:    if (mem.mem_ack && op == OP_LW) mdr <= mem.mem_rdata;
            default:  ;
        endcase
    end

`ifdef MCPU_TRAP_EN
    logic trap_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         trap_q <= 1'b0;
        else if (state == S_DECODE && !op_is_legal(op)) trap_q <= 1'b1;
    end
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    // Memory port is decoded from state so it is stable for the whole request
    logic store_cyc;
    assign store_cyc     = !rst && (state == S_MEM) && (op == OP_SW);
    assign mem.mem_req   = !rst && (state == S_FETCH || state == S_MEM);
    assign mem.mem_we    = store_cyc;
    assign mem.mem_wdata = store_cyc ? b_q : '0;
    assign mem.mem_addr  = rst ? '0 : (state == S_FETCH) ? pc : aluout[ADDR_W-1:0];

    assign halted = (state == S_HALT);
    assign pc_dbg = pc;
endmodule
